// File: rtl/bram_arbiter_pkg.sv
// bram_arbiter_pkg: shared types and constants for the two-port BRAM arbiter.
package bram_arbiter_pkg;
  typedef enum logic {ST_CLEAR, ST_RUN} state_t;
  localparam logic ID_CFG = 1'b0;
  localparam logic ID_ENG = 1'b1;
  localparam int DEF_DEPTH = 32;
  localparam logic [3:0] WE_ALL = 4'hF;
endpackage

// File: rtl/bram_arb_rr2.sv
// bram_arb_rr2: two-input round-robin grant with a registered pointer that
// flips only when both inputs contend.
module bram_arb_rr2
  import bram_arbiter_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);
  logic r_prio;
  logic w_both;
  assign w_both = &i_req;
  // r_prio names the port that wins the next contested cycle
  assign o_gnt = !i_en ? 2'b00 : w_both ? (r_prio == ID_ENG ? 2'b10 : 2'b01) : i_req;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_prio <= ID_CFG;
    else if (i_en && w_both) r_prio <= ~r_prio;
endmodule

// File: rtl/bram_arbiter.sv
// bram_arbiter: shares one single-port byte-writable BRAM between the config
// and engine ports; BRAM_ARBITER_CLEAR_EN adds a zero-fill sweep after reset.
module bram_arbiter
  import bram_arbiter_pkg::*;
#(
  parameter int AW    = 12,
  parameter int DW    = 32,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            c_req,
  input  logic [DW/8-1:0] c_we,
  input  logic [AW-1:0]   c_addr,
  input  logic [DW-1:0]   c_wdata,
  output logic            c_gnt,
  output logic            c_rvalid,
  output logic [DW-1:0]   c_rdata,
  input  logic            e_req,
  input  logic [DW/8-1:0] e_we,
  input  logic [AW-1:0]   e_addr,
  input  logic [DW-1:0]   e_wdata,
  output logic            e_gnt,
  output logic            e_rvalid,
  output logic [DW-1:0]   e_rdata,
  output logic            bram_EN,
  output logic [DW/8-1:0] bram_WE,
  output logic [AW-1:0]   bram_A,
  output logic [DW-1:0]   bram_Di,
  input  logic [DW-1:0]   bram_Do,
  output logic            clear_done
);
  logic            w_clear;
  logic [AW-1:0]   w_clr_a;
  logic [1:0]      w_gnt;
  logic            w_any;
  logic            w_sel_e;
  logic [DW/8-1:0] w_pwe;
  logic            r_pend_rd;
  logic            r_pend_id;
  logic [AW-1:0]   r_a;
  logic [DW-1:0]   r_di;
  logic [DW-1:0]   r_c_rdata;
  logic [DW-1:0]   r_e_rdata;

`ifdef BRAM_ARBITER_CLEAR_EN
  localparam int IW = $clog2(DEPTH);
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);
  state_t        r_state;
  logic [IW-1:0] r_i;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      r_state <= ST_CLEAR;
      r_i     <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_i <= r_i + 1'b1;
      if (r_i == LAST) r_state <= ST_RUN;
    end
  assign w_clear = r_state == ST_CLEAR;
  assign w_clr_a = AW'({r_i, 2'b00});
`else
  assign w_clear = 1'b0;
  assign w_clr_a = '0;
`endif

  assign clear_done = !w_clear;

  bram_arb_rr2 u_rr (
    .i_clk (CLK),
    .i_rst (RST),
    .i_en  (!w_clear && !RST),
    .i_req ({e_req, c_req}),
    .o_gnt (w_gnt)
  );

  assign c_gnt   = w_gnt[ID_CFG];
  assign e_gnt   = w_gnt[ID_ENG];
  assign w_any   = |w_gnt;
  assign w_sel_e = w_gnt[ID_ENG];
  assign w_pwe   = w_sel_e ? e_we : c_we;
  assign bram_WE = w_any ? w_pwe : w_clear ? WE_ALL : '0;
  assign bram_A  = w_any ? (w_sel_e ? e_addr : c_addr) : w_clear ? w_clr_a : r_a;
  assign bram_Di = w_any ? (w_sel_e ? e_wdata : c_wdata) : w_clear ? '0 : r_di;
  // EN stays up in a return cycle because the RAM output is gated by it
  assign bram_EN = !RST && (w_any || w_clear || r_pend_rd);

  assign c_rvalid = r_pend_rd && r_pend_id == ID_CFG;
  assign e_rvalid = r_pend_rd && r_pend_id == ID_ENG;
  assign c_rdata  = c_rvalid ? bram_Do : r_c_rdata;
  assign e_rdata  = e_rvalid ? bram_Do : r_e_rdata;

  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      r_pend_rd <= 1'b0;
      r_pend_id <= ID_CFG;
      r_a       <= '0;
      r_di      <= '0;
      r_c_rdata <= '0;
      r_e_rdata <= '0;
    end else begin
      r_pend_rd <= w_any && w_pwe == '0;
      r_pend_id <= w_sel_e;
      r_a       <= bram_A;
      r_di      <= bram_Di;
      r_c_rdata <= c_rdata;
      r_e_rdata <= e_rdata;
    end
endmodule
